// File: rtl/window_pkg.sv
// Shared definitions for the 5x5 window generator: window geometry,
// element-to-bit-offset mapping and the frame-tracking state encoding.
package window_pkg;

    localparam int WIN_N   = 5;
    localparam int WIN_CTR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Bit offset of window element (r,c), both 1-based, row-major.
    function automatic int win_idx(input int r, input int c, input int pix_w = 8);
        return ((r - 1) * WIN_N + (c - 1)) * pix_w;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular line store: one shared address, asynchronous read of the old
// contents while the new pixel is written at the same address.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window5x5_gen.sv
// Raster-stream to 5x5 sliding-window generator with four chained line buffers.
// Optional macro WIN_CENTER_COORD_EN adds win_cx/win_cy centre coordinates.
module window5x5_gen
    import window_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIX_W-1:0]           pix_in,
    input  logic                       pix_valid,
    input  logic                       sof,
    output logic [25*PIX_W-1:0]        win_out,
    output logic                       win_valid,
`ifdef WIN_CENTER_COORD_EN
    output logic [$clog2(IMG_W)-1:0]   win_cx,
    output logic [$clog2(IMG_H)-1:0]   win_cy,
`endif
    output logic                       frame_done
);

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int WIN_W = WIN_N * WIN_N * PIX_W;

    state_e             state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
`ifdef WIN_CENTER_COORD_EN
    logic [XW-1:0]      cx_q, cx_d;
    logic [YW-1:0]      cy_q, cy_d;
`endif

    logic               accept;
    logic               restart;
    logic               last_pix;
    logic [XW-1:0]      cur_x;
    logic [YW-1:0]      cur_y;
    logic [PIX_W-1:0]   lb_in  [WIN_N-1];
    logic [PIX_W-1:0]   lb_rd  [WIN_N-1];
    logic [PIX_W-1:0]   col_in [WIN_N];

    // A sof pixel is always (0,0), so the buffers must see address 0 on that cycle.
    assign restart = pix_valid & sof;
    assign cur_x   = restart ? '0 : x_q;
    assign cur_y   = restart ? '0 : y_q;
    assign accept  = pix_valid & (sof | (state_q == ACTIVE));

    assign col_in[WIN_N-1] = pix_in;

    for (genvar k = 0; k < WIN_N - 1; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_in[k] = pix_in;
        end else begin : g_chain
            assign lb_in[k] = lb_rd[k-1];
        end

        // Buffer k+1 holds row y-(k+1); it lands in window row WIN_N-1-k.
        assign col_in[WIN_N-2-k] = lb_rd[k];

        line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_lb (
            .clk     (clk),
            .we      (accept),
            .addr    (cur_x),
            .wr_data (lb_in[k]),
            .rd_data (lb_rd[k])
        );
    end

    // Next-state, counter, window-shift and strobe logic.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef WIN_CENTER_COORD_EN
        cx_d         = cx_q;
        cy_d         = cy_q;
`endif
        last_pix = (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));

        if (accept) begin
            for (int r = 1; r <= WIN_N; r++) begin
                for (int c = 1; c < WIN_N; c++) begin
                    win_d[win_idx(r, c, PIX_W) +: PIX_W] = win_q[win_idx(r, c + 1, PIX_W) +: PIX_W];
                end
                win_d[win_idx(r, WIN_N, PIX_W) +: PIX_W] = col_in[r-1];
            end
            win_valid_d  = (cur_x >= XW'(WIN_N - 1)) && (cur_y >= YW'(WIN_N - 1));
            frame_done_d = last_pix;
`ifdef WIN_CENTER_COORD_EN
            cx_d = cur_x - XW'(WIN_CTR);
            cy_d = cur_y - YW'(WIN_CTR);
`endif
            if (cur_x == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = last_pix ? '0 : cur_y + YW'(1);
            end else begin
                x_d = cur_x + XW'(1);
                y_d = cur_y;
            end
        end else begin
            win_d = win_q;
        end

        case (state_q)
            ACTIVE:    state_d = (accept && last_pix) ? DONE : ACTIVE;
            IDLE,
            DONE:      state_d = restart ? ACTIVE : state_q;
            default:   state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WIN_CENTER_COORD_EN
            cx_q         <= '0;
            cy_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
`ifdef WIN_CENTER_COORD_EN
            cx_q         <= cx_d;
            cy_q         <= cy_d;
`endif
        end
    end

    assign win_out    = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
`ifdef WIN_CENTER_COORD_EN
    assign win_cx     = cx_q;
    assign win_cy     = cy_q;
`endif

endmodule

// File: tb/tb_window5x5_gen.sv
// Directed, scoreboard-checked bench for window5x5_gen on an 8x6 image
// with pixel value y*16+x; checks coordinates when WIN_CENTER_COORD_EN is set.
module tb_window5x5_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int P  = 8;
    localparam int WW = 25 * P;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          sof;
    logic [P-1:0]  pix_in;
    logic [WW-1:0] win_out;
    logic          win_valid;
    logic          frame_done;
`ifdef WIN_CENTER_COORD_EN
    logic [2:0]    win_cx;
    logic [2:0]    win_cy;
`endif

    always #5 clk = ~clk;

    window5x5_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .win_out    (win_out),
        .win_valid  (win_valid),
`ifdef WIN_CENTER_COORD_EN
        .win_cx     (win_cx),
        .win_cy     (win_cy),
`endif
        .frame_done (frame_done)
    );

    typedef struct {
        logic          valid;
        logic          done;
        logic          chk_win;
        logic [WW-1:0] win;
        logic [2:0]    cx;
        logic [2:0]    cy;
    } exp_t;

    exp_t          sbq[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference model: frame tracker plus a plain image store.
    int            mstate = 0;
    int            mx = 0;
    int            my = 0;
    logic [P-1:0]  img [H][W];
    logic [WW-1:0] last_win = '0;
    logic          last_valid = 1'b0;

    // Per-frame observations.
    int            f_valid, f_done, f_acc, f_first_idx;
    logic [WW-1:0] f_first, f_last;
    logic [2:0]    f_first_cx, f_first_cy, f_last_cx, f_last_cy;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [P-1:0] p);
        exp_t e;
        int   cx, cy;
        bit   acc;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        e.valid = 1'b0; e.done = 1'b0; e.chk_win = 1'b0; e.win = '0; e.cx = '0; e.cy = '0;
        acc = v && (s || mstate == 1);
        if (acc) begin
            cx = s ? 0 : mx;
            cy = s ? 0 : my;
            img[cy][cx] = p;
            e.valid = (cx >= 4) && (cy >= 4);
            e.done  = (cx == W - 1) && (cy == H - 1);
            if (e.valid) begin
                for (int r = 1; r <= 5; r++)
                    for (int c = 1; c <= 5; c++)
                        e.win[((r - 1) * 5 + (c - 1)) * P +: P] = img[cy - 5 + r][cx - 5 + c];
                e.chk_win = 1'b1;
                e.cx = 3'(cx - 2);
                e.cy = 3'(cy - 2);
            end
            last_valid = e.valid;
            last_win   = e.win;
            mstate = e.done ? 2 : 1;
            mx = (cx == W - 1) ? 0 : cx + 1;
            my = (cx == W - 1) ? ((cy == H - 1) ? 0 : cy + 1) : cy;
            f_acc++;
        end else if (last_valid) begin
            e.chk_win = 1'b1;
            e.win     = last_win;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("win_valid", WW'(win_valid), WW'(e.valid));
        chk("frame_done", WW'(frame_done), WW'(e.done));
        if (e.chk_win) chk("win_out", win_out, e.win);
`ifdef WIN_CENTER_COORD_EN
        if (e.valid) begin
            chk("win_cx", WW'(win_cx), WW'(e.cx));
            chk("win_cy", WW'(win_cy), WW'(e.cy));
        end
`endif
        if (win_valid) begin
            f_valid++;
            if (f_valid == 1) begin
                f_first = win_out;
                f_first_idx = f_acc;
`ifdef WIN_CENTER_COORD_EN
                f_first_cx = win_cx; f_first_cy = win_cy;
`endif
            end
            f_last = win_out;
`ifdef WIN_CENTER_COORD_EN
            f_last_cx = win_cx; f_last_cy = win_cy;
`endif
        end
        if (frame_done) f_done++;
    endtask

    task automatic run_frame(input int idle_pct);
        f_valid = 0; f_done = 0; f_acc = 0; f_first_idx = -1;
        f_first = '0; f_last = '0;
        f_first_cx = '0; f_first_cy = '0; f_last_cx = '0; f_last_cy = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                while (int'($urandom_range(0, 99)) < idle_pct)
                    step(1'b0, 1'b0, 8'($urandom));
                step(1'b1, (x == 0) && (y == 0), 8'(y * 16 + x));
            end
        end
        chk("n_valid", WW'(f_valid), WW'(8));
        chk("n_done", WW'(f_done), WW'(1));
        chk("first_idx", WW'(f_first_idx), WW'(37));
        chk("first_11", WW'(f_first[0 +: P]), WW'(8'h00));
        chk("first_33", WW'(f_first[12 * P +: P]), WW'(8'h22));
        chk("first_55", WW'(f_first[24 * P +: P]), WW'(8'h44));
        chk("last_55", WW'(f_last[24 * P +: P]), WW'(8'h57));
`ifdef WIN_CENTER_COORD_EN
        chk("first_cx", WW'(f_first_cx), WW'(2));
        chk("first_cy", WW'(f_first_cy), WW'(2));
        chk("last_cx", WW'(f_last_cx), WW'(5));
        chk("last_cy", WW'(f_last_cy), WW'(3));
`endif
    endtask

    // Drive a frame from its sof up to, but excluding, pixel (sx,sy).
    task automatic partial(input int sx, input int sy);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (y * W + x < sy * W + sx)
                    step(1'b1, (x == 0) && (y == 0), 8'(y * 16 + x));
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_out", win_out, '0);
        chk("rst_win_valid", WW'(win_valid), '0);
        chk("rst_frame_done", WW'(frame_done), '0);
        rst = 1'b0;

        // Pixels in IDLE without sof are ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));

        run_frame(0);

        // After frame_done, non-sof pixels are ignored.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'($urandom));

        run_frame(30);

        partial(3, 2);
        run_frame(0);

        partial(6, 4);
        rst = 1'b1; pix_valid = 1'b1; sof = 1'b0; pix_in = 8'h46;
        @(posedge clk);
        #1;
        chk("midrst_win_out", win_out, '0);
        chk("midrst_win_valid", WW'(win_valid), '0);
        chk("midrst_frame_done", WW'(frame_done), '0);
        rst = 1'b0;
        mstate = 0; mx = 0; my = 0; last_valid = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom));
        run_frame(0);

        step(1'b0, 1'b0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window5x5_gen.md
Name: window5x5_gen

Overview:
- Upstream feeder for the 5x5 DoG summation stage.
- Accepts a raster-order 8-bit pixel stream and maintains four line buffers plus a 5x5 shift-register window.
- Presents the 25 window pixels, with a valid strobe, in the row/column layout that stage consumes.
- Windows overlapping the image border are never marked valid.

Parameters:
- IMG_W, 640, pixels per line (>=5).
- IMG_H, 480, lines per frame (>=5).
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in is accepted on this cycle when high; no back-pressure.
- sof  in  1  qualified by pix_valid: the current pixel is (x=0, y=0) of a new frame.
- win_out  out  25*PIX_W  window, row-major. Element (r,c), r,c in 1..5, sits at bits [((r-1)*5+(c-1))*PIX_W +: PIX_W]. r=1 is the oldest line, c=1 the oldest column; (5,5) is the newest pixel.
- win_valid  out  1  win_out holds a complete, in-image 5x5 window.
- frame_done  out  1  one-cycle pulse after the last pixel (IMG_W-1, IMG_H-1) is accepted.
- Interface rule: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset:
  - win_out=0, win_valid=0, frame_done=0.
  - x/y counters=0, FSM=IDLE.
  - Line-buffer contents need not be cleared.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE->ACTIVE on pix_valid&sof; all other pixels in IDLE are ignored.
  - ACTIVE->DONE on acceptance of pixel (IMG_W-1, IMG_H-1).
  - DONE->ACTIVE on pix_valid&sof; non-sof pixels in DONE are ignored.
  - In any state, pix_valid&sof restarts the frame: the pixel is treated as (0,0) and counters reload. This covers a mid-frame sof.
- Accepted pixel handling (ACTIVE, or the sof pixel itself):
  - Four circular line buffers, depth IMG_W, share a column address = x.
  - Line buffer k outputs the pixel from row y-k at column x, for k=1..4.
  - The column vector {lb4,lb3,lb2,lb1,pix_in} shifts into window column 5; existing columns shift toward column 1.
  - x increments; at IMG_W-1 it wraps to 0 and y increments.
- Latency: win_out and win_valid update on the clock edge that accepts the pixel, i.e. registered 1 cycle after pix_in is presented.
- win_valid = 1 for the cycle following acceptance of a pixel with x>=4 and y>=4. Otherwise it is 0, including every non-accepting cycle.
- Stall (pix_valid=0): window, counters and line buffers hold; win_valid drops to 0.
- Valid windows per frame: (IMG_W-4)*(IMG_H-4).
- Stale line-buffer data from a previous or aborted frame is harmless, because validity requires y>=4.
- rst mid-frame: immediate return to IDLE. No valid output until the next sof and four full lines.
- frame_done and win_valid may assert in the same cycle (last window).

Optional Feature:
- Macro WIN_CENTER_COORD_EN.
- When defined: adds outputs win_cx and win_cy, widths $clog2(IMG_W) and $clog2(IMG_H).
  - They give the image coordinate of window element (3,3): x-2, y-2 of the accepted pixel.
  - Registered alongside win_out; reset to 0.
  - Meaningful only while win_valid=1.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package window_pkg:
  - localparam WIN_N=5, WIN_CTR=2.
  - Function win_idx(r,c) returning the bit offset.
  - FSM state enum {IDLE, ACTIVE, DONE}.
- One sub-module, line_buffer: single-port-read/write circular RAM with parameters DEPTH and WIDTH.
  - Read-before-write at the same address.
  - Instantiated four times, chained (output of k feeds input of k+1).

Test Plan (IMG_W=8, IMG_H=6, pixel = y*16+x):
- Full frame, continuous pix_valid:
  - First win_valid after accepted pixel (4,4), i.e. the 37th pixel.
  - Window (1,1)=0x00, (3,3)=0x22, (5,5)=0x44.
  - Exactly 8 valid windows in total; last window (5,5)=0x57.
  - frame_done pulses once.
- Random pix_valid gaps (30% idle): the same 8 windows with identical contents. win_valid never asserts on idle cycles, and the window holds across gaps.
- Mid-frame sof at pixel (3,2), then a full frame: no valid window before the new (4,4). New-frame windows match case 1.
- rst asserted at pixel (6,4) for one cycle:
  - All outputs 0 next cycle.
  - Pixels without sof are ignored.
  - A subsequent full frame matches case 1.
- Pixels after frame_done without sof: no win_valid and no frame_done. A following sof frame behaves as case 1.
- With WIN_CENTER_COORD_EN: the first valid window reports (2,2) and the last reports (5,3). Without the macro, the design compiles and case 1 passes.
